spectrum_peak_sorter: RTL and testbench
=======================================

// Module: spectrum_peak_sorter
// PURPOSE
//  Streams one FFT magnitude frame (CORDIC sqrt output) and keeps the K strongest local-maximum bins
//  inside a configurable bin window, sorted by magnitude. Generalises the fixed two-tone max search
//  to K peaks with local-max qualification, a threshold, DC/mirror exclusion and frame-length check.
//  Sits between the magnitude CORDIC and the tone-separation / IFFT-mask logic.
// PARAMETERS
//  MAG_W    32    magnitude sample width (unsigned)
//  IDX_W    10    bin index width
//  N_FFT    1024  bins per frame
//  K        2     peaks kept (1..8)
//  BIN_MIN  1     lowest candidate bin (1 excludes DC)
//  BIN_MAX  511   highest candidate bin (N_FFT/2-1 excludes mirror half)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous active-high reset
//  s_tvalid   in   1          magnitude sample valid
//  s_tready   out  1          block accepts sample (low only in FLUSH/COMMIT)
//  s_tdata    in   MAG_W      magnitude of current bin
//  s_tlast    in   1          last bin of frame
//  thr        in   MAG_W      minimum candidate magnitude; stable for whole frame
//  peak_val   out  K*MAG_W    sorted magnitudes, slot 0 = largest at [MAG_W-1:0]
//  peak_idx   out  K*IDX_W    bin index per slot, same packing
//  peak_cnt   out  4          filled slots, 0..K
//  done       out  1          one-cycle pulse: outputs updated for a new frame
//  frame_err  out  1          registered with done: frame length != N_FFT
// BEHAVIOUR
//  - One clock, rst synchronous active-high. Reset: state ACC, bin=0, working list cleared,
//    peak_val/peak_idx/peak_cnt=0, done=0, frame_err=0, s_tready=1. Reset mid-frame discards frame.
//  - Accept = s_tvalid & s_tready. bin counter increments per accept; wraps to 0 at frame end.
//  - Window regs prev (bin k-1) / cur (bin k). On accept of bin k+1, bin k is evaluated using
//    prev, cur, s_tdata; first bin of frame uses prev=0; no evaluation on the first accept.
//  - Candidate: cur > prev AND cur >= next AND cur >= thr AND BIN_MIN <= k <= BIN_MAX.
//    Plateaus resolve to leftmost bin.
//  - Insertion in same cycle: position p = first slot with val < cand (strict, earlier bin wins
//    ties); slots p..K-2 shift to p+1..K-1; slot K-1 dropped; cnt saturates at K. Max 1/cycle.
//  - FSM: ACC -> FLUSH on accept with s_tlast or bin==N_FFT-1 (frame end).
//    FLUSH (1 cycle, s_tready=0): last bin evaluated with next=0, inserted. -> COMMIT.
//    COMMIT (1 cycle, s_tready=0): working list -> outputs, done=1, frame_err set, working list
//    and window cleared, bin=0. -> ACC.
//  - Latency: done is high the 2nd cycle after the frame-end accept cycle.
//  - frame_err=1 if s_tlast at bin != N_FFT-1, or bin N_FFT-1 accepted without s_tlast
//    (frame forced to end there). Results committed regardless.
//  - Outputs hold between done pulses. Empty slots read val=0, idx=0.
//  - Magnitude compares are unsigned, full MAG_W; no arithmetic widening.
// TESTING
//  1 Bins 100=5000, 300=3000, others 10, thr=100 -> slot0=(5000,100), slot1=(3000,300), cnt=2,
//    done 2 cycles after tlast, frame_err=0.
//  2 Leakage: 99=4000,100=5000,101=4500, 300=3000 -> (5000,100),(3000,300); 101 never selected.
//  3 Exclusion: bin0=9999, bin700=8000, bin50=200, thr=100 -> cnt=1, slot0=(200,50).
//  4 Tie + threshold: bins 40,80 both 600, thr=700 -> cnt=0; thr=500 -> (600,40),(600,80).
//  5 Framing: tlast at bin 500 -> frame_err=1, done pulses; continuous s_tvalid across two frames
//    -> s_tready low exactly 2 cycles, no sample lost, second frame results correct.
//  6 rst asserted at bin 400 -> all outputs 0 next cycle; following full frame reports correctly.

Source files
------------

// File: rtl/spectrum_peak_sorter.sv
// Streaming K-peak sorter for one FFT magnitude frame.
// Keeps the K strongest local-maximum bins inside [BIN_MIN, BIN_MAX] that meet the threshold,
// sorted by magnitude (slot 0 = largest). Results are published once per frame with a done pulse.
module spectrum_peak_sorter #(
  parameter int unsigned MAG_W   = 32,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned N_FFT   = 1024,
  parameter int unsigned K       = 2,
  parameter int unsigned BIN_MIN = 1,
  parameter int unsigned BIN_MAX = 511
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [MAG_W-1:0]     s_tdata,
  input  logic                 s_tlast,
  input  logic [MAG_W-1:0]     thr,
  output logic [K*MAG_W-1:0]   peak_val,
  output logic [K*IDX_W-1:0]   peak_idx,
  output logic [3:0]           peak_cnt,
  output logic                 done,
  output logic                 frame_err
);

  typedef enum logic [1:0] {StAcc, StFlush, StCommit} state_e;

  localparam logic [IDX_W-1:0] LastBin = IDX_W'(N_FFT - 1);
  localparam logic [IDX_W-1:0] BinLo   = IDX_W'(BIN_MIN);
  localparam logic [IDX_W-1:0] BinHi   = IDX_W'(BIN_MAX);
  localparam logic [3:0]       KCnt    = 4'(K);

  state_e           state_q;
  logic [IDX_W-1:0] bin_q;
  logic [MAG_W-1:0] prev_q, cur_q;
  logic             err_q;

  // Working list, kept sorted; empty slots hold zero so any qualifying candidate (>= 1) beats them.
  logic [MAG_W-1:0] wval_q [K];
  logic [IDX_W-1:0] widx_q [K];
  logic [3:0]       wcnt_q;
  logic [MAG_W-1:0] wval_d [K];
  logic [IDX_W-1:0] widx_d [K];
  logic [3:0]       wcnt_d;

  logic             accept, frame_end;
  logic             eval_en, cand_ok;
  logic [MAG_W-1:0] next_mag;
  logic [IDX_W-1:0] ev_idx;
  logic [K-1:0]     gt;

  assign accept    = s_tvalid & s_tready;
  assign frame_end = accept & (s_tlast | (bin_q == LastBin));

  // Select which bin is judged this cycle: bin k-1 on a streaming accept, the final bin in flush.
  always_comb begin
    eval_en  = 1'b0;
    next_mag = s_tdata;
    ev_idx   = bin_q - IDX_W'(1);
    if (state_q == StFlush) begin
      eval_en  = 1'b1;
      next_mag = '0;
      ev_idx   = bin_q;
    end else if (state_q == StAcc && accept && bin_q != '0) begin
      eval_en = 1'b1;
    end
  end

  // Strict rise on the left, non-strict on the right: plateaus resolve to their leftmost bin.
  assign cand_ok = eval_en && (cur_q > prev_q) && (cur_q >= next_mag) && (cur_q >= thr) &&
                   (ev_idx >= BinLo) && (ev_idx <= BinHi);

  // Sorted insertion: slots where the candidate is strictly larger shift down by one.
  always_comb begin
    wcnt_d = wcnt_q;
    for (int i = 0; i < K; i++) begin
      gt[i]     = cand_ok && (cur_q > wval_q[i]);
      wval_d[i] = wval_q[i];
      widx_d[i] = widx_q[i];
    end
    if (gt[0]) begin
      wval_d[0] = cur_q;
      widx_d[0] = ev_idx;
    end
    for (int i = 1; i < K; i++) begin
      if (gt[i]) begin
        if (gt[i-1]) begin
          wval_d[i] = wval_q[i-1];
          widx_d[i] = widx_q[i-1];
        end else begin
          wval_d[i] = cur_q;
          widx_d[i] = ev_idx;
        end
      end
    end
    if (gt[K-1] && wcnt_q != KCnt) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Frame FSM, bin window, working list and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      bin_q     <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
      for (int i = 0; i < K; i++) begin
        wval_q[i] <= '0;
        widx_q[i] <= '0;
      end
      peak_val  <= '0;
      peak_idx  <= '0;
      peak_cnt  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      s_tready  <= 1'b1;
    end else begin
      done   <= 1'b0;
      wcnt_q <= wcnt_d;
      for (int i = 0; i < K; i++) begin
        wval_q[i] <= wval_d[i];
        widx_q[i] <= widx_d[i];
      end
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            prev_q <= cur_q;
            cur_q  <= s_tdata;
            if (frame_end) begin
              // bin_q holds the last bin index through flush.
              state_q  <= StFlush;
              s_tready <= 1'b0;
              err_q    <= s_tlast ^ (bin_q == LastBin);
            end else begin
              bin_q <= bin_q + IDX_W'(1);
            end
          end
        end
        StFlush: begin
          // Publish the post-insertion list so done lines up with the commit cycle.
          state_q   <= StCommit;
          for (int i = 0; i < K; i++) begin
            peak_val[i*MAG_W +: MAG_W] <= wval_d[i];
            peak_idx[i*IDX_W +: IDX_W] <= widx_d[i];
          end
          peak_cnt  <= wcnt_d;
          frame_err <= err_q;
          done      <= 1'b1;
        end
        StCommit: begin
          state_q  <= StAcc;
          s_tready <= 1'b1;
          bin_q    <= '0;
          prev_q   <= '0;
          cur_q    <= '0;
          err_q    <= 1'b0;
          wcnt_q   <= '0;
          for (int i = 0; i < K; i++) begin
            wval_q[i] <= '0;
            widx_q[i] <= '0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_peak_sorter.sv
// Self-checking bench for spectrum_peak_sorter: directed scenarios plus randomized frames
// checked against a list-based reference model.
module tb_spectrum_peak_sorter;

  localparam int MAG_W   = 32;
  localparam int IDX_W   = 10;
  localparam int N_FFT   = 1024;
  localparam int K       = 2;
  localparam int BIN_MIN = 1;
  localparam int BIN_MAX = 511;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_tvalid, s_tready, s_tlast;
  logic [MAG_W-1:0]   s_tdata, thr;
  logic [K*MAG_W-1:0] peak_val;
  logic [K*IDX_W-1:0] peak_idx;
  logic [3:0]         peak_cnt;
  logic               done, frame_err;

  always #5 clk = ~clk;

  spectrum_peak_sorter #(
    .MAG_W(MAG_W), .IDX_W(IDX_W), .N_FFT(N_FFT), .K(K), .BIN_MIN(BIN_MIN), .BIN_MAX(BIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .thr(thr), .peak_val(peak_val), .peak_idx(peak_idx),
    .peak_cnt(peak_cnt), .done(done), .frame_err(frame_err)
  );

  typedef struct {
    logic [K*MAG_W-1:0] val;
    logic [K*IDX_W-1:0] idx;
    logic [3:0]         cnt;
    logic               err;
    int                 c;
  } res_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int low_cnt = 0;
  res_t res_q[$];
  logic [MAG_W-1:0] mag [2][N_FFT];

  logic [K*MAG_W-1:0] m_val;
  logic [K*IDX_W-1:0] m_idx;
  int                 m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every published result and count stalled cycles.
  always @(negedge clk) begin
    if (done) res_q.push_back('{peak_val, peak_idx, peak_cnt, frame_err, cyc});
    if (!rst && !s_tready) low_cnt <= low_cnt + 1;
  end

  task automatic fill_const(input int f, input logic [MAG_W-1:0] v);
    for (int i = 0; i < N_FFT; i++) mag[f][i] = v;
  endtask

  task automatic fill_rand(input int f);
    for (int i = 0; i < N_FFT; i++) mag[f][i] = MAG_W'($urandom_range(0, 63));
    for (int p = 0; p < 6; p++) mag[f][$urandom_range(0, N_FFT - 1)] = MAG_W'($urandom_range(64, 100000));
    mag[f][$urandom_range(BIN_MIN, BIN_MAX)] = $urandom() | 32'h8000_0000;
  endtask

  // Reference: enumerate local maxima from the whole frame, then pick the K largest,
  // earliest bin first on equal magnitude.
  task automatic model(input int f, input int len, input logic [MAG_W-1:0] t);
    logic [MAG_W-1:0] cv[$];
    int               ci[$];
    bit               taken[$];
    logic [MAG_W-1:0] p, c, n;
    int               best;
    m_val = '0;
    m_idx = '0;
    m_cnt = 0;
    for (int k = 0; k < len; k++) begin
      p = (k == 0) ? '0 : mag[f][k-1];
      c = mag[f][k];
      n = (k == len - 1) ? '0 : mag[f][k+1];
      if (c > p && c >= n && c >= t && k >= BIN_MIN && k <= BIN_MAX) begin
        cv.push_back(c);
        ci.push_back(k);
        taken.push_back(1'b0);
      end
    end
    for (int s = 0; s < K; s++) begin
      best = -1;
      for (int j = 0; j < cv.size(); j++)
        if (!taken[j] && (best < 0 || cv[j] > cv[best])) best = j;
      if (best >= 0) begin
        taken[best] = 1'b1;
        m_val[s*MAG_W +: MAG_W] = cv[best];
        m_idx[s*IDX_W +: IDX_W] = IDX_W'(ci[best]);
        m_cnt++;
      end
    end
  endtask

  // Stream len bins of buffer f; end_c is the cycle number of the final accept.
  task automatic drive(input int f, input int len, input bit last, output int end_c);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    end_c = -1;
    while (i < len) begin
      s_tvalid = 1'b1;
      s_tdata  = mag[f][i];
      s_tlast  = last && (i == len - 1);
      acc = s_tready;
      if (acc && i == len - 1) end_c = cyc;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > len + 50) begin
        $display("FAIL drive_stall: got s_tready low for %0d cycles, required accept", guard);
        $fatal(1, "stream stalled");
      end
    end
  endtask

  task automatic get_result(output res_t r, output bit ok);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && res_q.size() == 0; n++) @(posedge clk);
    #1;
    if (res_q.size() > 0) begin
      r  = res_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests += 6;
    if (peak_val !== '0) begin fails++; $display("FAIL reset_val: got %0h required 0", peak_val); end
    if (peak_idx !== '0) begin fails++; $display("FAIL reset_idx: got %0h required 0", peak_idx); end
    if (peak_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d required 0", peak_cnt); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", frame_err); end
    if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_tready: got %b required 1", s_tready); end
    rst = 1'b0;
  endtask

  task automatic test_two_tones();
    res_t r; bit ok; int ec;
    fill_const(0, 10);
    mag[0][100] = 5000;
    mag[0][300] = 3000;
    thr = 100;
    drive(0, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL two_tones_done: got no pulse required pulse"); end
    else begin
      tests += 5;
      if (r.val !== {MAG_W'(3000), MAG_W'(5000)}) begin fails++; $display("FAIL two_tones_val: got %0h required %0h", r.val, {MAG_W'(3000), MAG_W'(5000)}); end
      if (r.idx !== {IDX_W'(300), IDX_W'(100)}) begin fails++; $display("FAIL two_tones_idx: got %0h required %0h", r.idx, {IDX_W'(300), IDX_W'(100)}); end
      if (r.cnt !== 4'd2) begin fails++; $display("FAIL two_tones_cnt: got %0d required 2", r.cnt); end
      if (r.err !== 1'b0) begin fails++; $display("FAIL two_tones_err: got %b required 0", r.err); end
      if (r.c - ec != 2) begin fails++; $display("FAIL two_tones_latency: got %0d required 2", r.c - ec); end
    end
  endtask

  task automatic test_leakage();
    res_t r; bit ok; int ec;
    fill_const(0, 10);
    mag[0][99]  = 4000;
    mag[0][100] = 5000;
    mag[0][101] = 4500;
    mag[0][300] = 3000;
    thr = 100;
    drive(0, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL leakage_done: got no pulse required pulse"); end
    else begin
      tests += 3;
      if (r.val !== {MAG_W'(3000), MAG_W'(5000)}) begin fails++; $display("FAIL leakage_val: got %0h required %0h", r.val, {MAG_W'(3000), MAG_W'(5000)}); end
      if (r.idx !== {IDX_W'(300), IDX_W'(100)}) begin fails++; $display("FAIL leakage_idx: got %0h required %0h", r.idx, {IDX_W'(300), IDX_W'(100)}); end
      if (r.cnt !== 4'd2) begin fails++; $display("FAIL leakage_cnt: got %0d required 2", r.cnt); end
    end
  endtask

  task automatic test_exclusion();
    res_t r; bit ok; int ec;
    fill_const(0, 10);
    mag[0][0]   = 9999;
    mag[0][700] = 8000;
    mag[0][50]  = 200;
    thr = 100;
    drive(0, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL exclusion_done: got no pulse required pulse"); end
    else begin
      tests += 3;
      if (r.val !== {MAG_W'(0), MAG_W'(200)}) begin fails++; $display("FAIL exclusion_val: got %0h required %0h", r.val, {MAG_W'(0), MAG_W'(200)}); end
      if (r.idx !== {IDX_W'(0), IDX_W'(50)}) begin fails++; $display("FAIL exclusion_idx: got %0h required %0h", r.idx, {IDX_W'(0), IDX_W'(50)}); end
      if (r.cnt !== 4'd1) begin fails++; $display("FAIL exclusion_cnt: got %0d required 1", r.cnt); end
    end
  endtask

  task automatic test_tie_thr();
    res_t r; bit ok; int ec;
    fill_const(0, 10);
    mag[0][40] = 600;
    mag[0][80] = 600;
    thr = 700;
    drive(0, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tie_high_thr_done: got no pulse required pulse"); end
    else begin
      tests += 2;
      if (r.cnt !== 4'd0) begin fails++; $display("FAIL tie_high_thr_cnt: got %0d required 0", r.cnt); end
      if (r.val !== '0) begin fails++; $display("FAIL tie_high_thr_val: got %0h required 0", r.val); end
    end
    thr = 500;
    drive(0, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tie_done: got no pulse required pulse"); end
    else begin
      tests += 3;
      if (r.val !== {MAG_W'(600), MAG_W'(600)}) begin fails++; $display("FAIL tie_val: got %0h required %0h", r.val, {MAG_W'(600), MAG_W'(600)}); end
      if (r.idx !== {IDX_W'(80), IDX_W'(40)}) begin fails++; $display("FAIL tie_idx: got %0h required %0h", r.idx, {IDX_W'(80), IDX_W'(40)}); end
      if (r.cnt !== 4'd2) begin fails++; $display("FAIL tie_cnt: got %0d required 2", r.cnt); end
    end
  endtask

  // Short frame (tlast at bin 500) and an over-long frame with no tlast (forced end at N_FFT-1).
  task automatic test_framing();
    res_t r; bit ok; int ec;
    int   lens[2]  = '{501, N_FFT};
    bit   lasts[2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      fill_rand(0);
      thr = MAG_W'($urandom_range(0, 80));
      model(0, lens[t], thr);
      drive(0, lens[t], lasts[t], ec);
      get_result(r, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL framing%0d_done: got no pulse required pulse", t); end
      else begin
        tests += 5;
        if (r.val !== m_val) begin fails++; $display("FAIL framing%0d_val: got %0h required %0h", t, r.val, m_val); end
        if (r.idx !== m_idx) begin fails++; $display("FAIL framing%0d_idx: got %0h required %0h", t, r.idx, m_idx); end
        if (r.cnt !== 4'(m_cnt)) begin fails++; $display("FAIL framing%0d_cnt: got %0d required %0d", t, r.cnt, m_cnt); end
        if (r.err !== 1'b1) begin fails++; $display("FAIL framing%0d_err: got %b required 1", t, r.err); end
        if (r.c - ec != 2) begin fails++; $display("FAIL framing%0d_latency: got %0d required 2", t, r.c - ec); end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r; bit ok; int ec0, ec1, low0, low1;
    fill_rand(0);
    fill_rand(1);
    thr = MAG_W'($urandom_range(0, 80));
    low0 = low_cnt;
    drive(0, N_FFT, 1'b1, ec0);
    drive(1, N_FFT, 1'b1, ec1);
    low1 = low_cnt;
    tests++;
    if (low1 - low0 != 2) begin fails++; $display("FAIL b2b_tready_low: got %0d cycles required 2", low1 - low0); end
    for (int f = 0; f < 2; f++) begin
      get_result(r, ok);
      model(f, N_FFT, thr);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b%0d_done: got no pulse required pulse", f); end
      else begin
        tests += 4;
        if (r.val !== m_val) begin fails++; $display("FAIL b2b%0d_val: got %0h required %0h", f, r.val, m_val); end
        if (r.idx !== m_idx) begin fails++; $display("FAIL b2b%0d_idx: got %0h required %0h", f, r.idx, m_idx); end
        if (r.cnt !== 4'(m_cnt)) begin fails++; $display("FAIL b2b%0d_cnt: got %0d required %0d", f, r.cnt, m_cnt); end
        if (r.err !== 1'b0) begin fails++; $display("FAIL b2b%0d_err: got %b required 0", f, r.err); end
      end
    end
  endtask

  task automatic test_random();
    res_t r; bit ok; int ec, len;
    for (int t = 0; t < 3; t++) begin
      fill_rand(0);
      thr = MAG_W'($urandom_range(0, 80));
      len = ($urandom_range(0, 1) == 1) ? N_FFT : $urandom_range(2, N_FFT - 1);
      model(0, len, thr);
      drive(0, len, 1'b1, ec);
      get_result(r, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL random%0d_done: got no pulse required pulse", t); end
      else begin
        tests += 4;
        if (r.val !== m_val) begin fails++; $display("FAIL random%0d_val: got %0h required %0h", t, r.val, m_val); end
        if (r.idx !== m_idx) begin fails++; $display("FAIL random%0d_idx: got %0h required %0h", t, r.idx, m_idx); end
        if (r.cnt !== 4'(m_cnt)) begin fails++; $display("FAIL random%0d_cnt: got %0d required %0d", t, r.cnt, m_cnt); end
        if (r.err !== (len != N_FFT)) begin fails++; $display("FAIL random%0d_err: got %b required %b", t, r.err, len != N_FFT); end
      end
    end
  endtask

  task automatic test_mid_reset();
    res_t r; bit ok; int ec;
    fill_rand(0);
    thr = 0;
    drive(0, 401, 1'b0, ec);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests += 5;
    if (peak_val !== '0) begin fails++; $display("FAIL midrst_val: got %0h required 0", peak_val); end
    if (peak_idx !== '0) begin fails++; $display("FAIL midrst_idx: got %0h required 0", peak_idx); end
    if (peak_cnt !== 4'd0) begin fails++; $display("FAIL midrst_cnt: got %0d required 0", peak_cnt); end
    if (s_tready !== 1'b1) begin fails++; $display("FAIL midrst_tready: got %b required 1", s_tready); end
    if (res_q.size() != 0) begin fails++; $display("FAIL midrst_spurious_done: got %0d results required 0", res_q.size()); end
    fill_rand(1);
    thr = MAG_W'($urandom_range(0, 80));
    model(1, N_FFT, thr);
    drive(1, N_FFT, 1'b1, ec);
    get_result(r, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_frame_done: got no pulse required pulse"); end
    else begin
      tests += 4;
      if (r.val !== m_val) begin fails++; $display("FAIL midrst_frame_val: got %0h required %0h", r.val, m_val); end
      if (r.idx !== m_idx) begin fails++; $display("FAIL midrst_frame_idx: got %0h required %0h", r.idx, m_idx); end
      if (r.cnt !== 4'(m_cnt)) begin fails++; $display("FAIL midrst_frame_cnt: got %0d required %0d", r.cnt, m_cnt); end
      if (r.err !== 1'b0) begin fails++; $display("FAIL midrst_frame_err: got %b required 0", r.err); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    thr      = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_two_tones();
    test_leakage();
    test_exclusion();
    test_tie_thr();
    test_framing();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
